// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/
// write-back steps, with memory wait-state timeout and retire counting.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             retire,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TO = WW'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        ADDI_EXEC = 4'd9,
        ADDI_WB   = 4'd10,
        JUMP      = 4'd11
    } state_e;

    state_e            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              waiting;
    logic              timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        waiting    = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                waiting   = !mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    6'h00:        state_d = R_EXEC;
                    6'h23, 6'h2B: state_d = MEM_ADDR;
                    6'h04:        state_d = BRANCH;
                    6'h08:        state_d = ADDI_EXEC;
                    6'h02:        state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == 6'h2B) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                waiting  = !mem_ready;
                state_d  = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_ready;
                waiting   = !mem_ready;
                state_d   = mem_ready ? FETCH : MEM_WR;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = zero;
                retire    = 1'b1;
            end
            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // A late ready on the timeout cycle still wins: waiting is already 0.
        timeout = waiting && (wait_q == TO);
        if (timeout) begin
            bus_err   = 1'b1;
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            mem_write = 1'b0;
            state_d   = FETCH;
        end

        if (!rst_n) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            retire    = 1'b0;
            illegal   = 1'b0;
            bus_err   = 1'b0;
        end

        if (timeout || state_d != state_q) begin
            wait_d = '0;
        end else if (waiting) begin
            wait_d = wait_q + WW'(1);
        end else begin
            wait_d = '0;
        end

        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized instruction-level bench for mc_ctrl_fsm, checked against
// a per-instruction step model with wait states and timeouts.
module tb_mc_ctrl_fsm;

    localparam int TO  = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          pc_en;
    logic [1:0]    pc_src;
    logic          ir_write;
    logic          i_or_d;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic          reg_dst;
    logic          mem_to_reg;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [1:0]    alu_op;
    logic [3:0]    state;
    logic          retire;
    logic          illegal;
    logic          bus_err;
    logic [CW-1:0] instr_count;
    logic [17:0]   ctl;

    int n_chk = 0;
    int n_err = 0;
    int m_cnt = 0;

    mc_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .retire(retire), .illegal(illegal), .bus_err(bus_err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_en, pc_src, ir_write, i_or_d, mem_read, mem_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                  alu_op, retire, illegal, bus_err};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected control word for one step, straight from the step table.
    function automatic logic [17:0] exp_out(input int s, input bit rdy,
                                            input bit z, input bit ill,
                                            input bit be);
        bit pe = 0, iw = 0, iod = 0, mr = 0, mw = 0, rw = 0;
        bit rd = 0, m2r = 0, asa = 0, ret = 0;
        bit [1:0] ps = 0, asb = 0, aop = 0;
        case (s)
            0:  begin mr = 1; asb = 1; pe = rdy; iw = rdy; end
            1:  asb = 3;
            2:  begin asa = 1; asb = 2; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; ret = 1; end
            5:  begin mw = 1; iod = 1; ret = rdy; end
            6:  begin asa = 1; aop = 2; end
            7:  begin rw = 1; rd = 1; ret = 1; end
            8:  begin asa = 1; aop = 1; ps = 1; pe = z; ret = 1; end
            9:  begin asa = 1; asb = 2; end
            10: begin rw = 1; ret = 1; end
            11: begin ps = 2; pe = 1; ret = 1; end
            default: ;
        endcase
        if (be) begin
            pe = 0; iw = 0; mw = 0;
        end
        return {pe, ps, iw, iod, mr, mw, rw, rd, m2r, asa, asb, aop,
                ret, ill, be};
    endfunction

    // One clock: drive, check mid-cycle, leave #1 after the next edge.
    task automatic cyc(input bit rdy, input int s, input bit ill,
                       input bit be);
        mem_ready = rdy;
        @(negedge clk);
        check("state", 32'(state), 32'(s));
        check("ctl", 32'(ctl), 32'(exp_out(s, rdy, zero, ill, be)));
        @(posedge clk);
        #1;
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Wait-capable step: w cycles with ready low, then a ready cycle.
    task automatic wait_step(input int s, input int w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < w; i++) begin
            if (i == TO) begin
                cyc(1'b0, s, 1'b0, 1'b1);
                return;
            end
            cyc(1'b0, s, 1'b0, 1'b0);
        end
        cyc(1'b1, s, 1'b0, 1'b0);
        ok = 1'b1;
    endtask

    task automatic do_instr(input logic [5:0] op, input bit z,
                            input int wf, input int wm);
        bit ok;
        bit legal;
        opcode = op;
        zero   = z;
        wait_step(0, wf, ok);
        if (ok) begin
            legal = (op == 6'h00 || op == 6'h23 || op == 6'h2B ||
                     op == 6'h04 || op == 6'h08 || op == 6'h02);
            cyc(rnd(), 1, !legal, 1'b0);
            case (op)
                6'h00: begin
                    cyc(rnd(), 6, 1'b0, 1'b0);
                    cyc(rnd(), 7, 1'b0, 1'b0);
                    m_cnt++;
                end
                6'h23: begin
                    cyc(rnd(), 2, 1'b0, 1'b0);
                    wait_step(3, wm, ok);
                    if (ok) begin
                        cyc(rnd(), 4, 1'b0, 1'b0);
                        m_cnt++;
                    end
                end
                6'h2B: begin
                    cyc(rnd(), 2, 1'b0, 1'b0);
                    wait_step(5, wm, ok);
                    if (ok) m_cnt++;
                end
                6'h04: begin
                    cyc(rnd(), 8, 1'b0, 1'b0);
                    m_cnt++;
                end
                6'h08: begin
                    cyc(rnd(), 9, 1'b0, 1'b0);
                    cyc(rnd(), 10, 1'b0, 1'b0);
                    m_cnt++;
                end
                6'h02: begin
                    cyc(rnd(), 11, 1'b0, 1'b0);
                    m_cnt++;
                end
                default: ;
            endcase
        end
        m_cnt = m_cnt % (1 << CW);
        check("count", 32'(instr_count), 32'(m_cnt));
    endtask

    task automatic chk_reset();
        mem_ready = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_en", 32'({pc_en, ir_write, reg_write, mem_write}), 32'd0);
        check("rst_pulse", 32'({retire, illegal, bus_err}), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        m_cnt = 0;
    endtask

    function automatic int rwait();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(4, 6));
        return int'($urandom_range(0, 2));
    endfunction

    initial begin
        logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
        logic [5:0] op;
        rst_n     = 1'b0;
        opcode    = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #12;
        chk_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_instr(6'h00, 1'b0, 0, 0);
        do_instr(6'h23, 1'b0, 0, 3);
        do_instr(6'h04, 1'b1, 0, 0);
        do_instr(6'h04, 1'b0, 0, 0);
        do_instr(6'h3F, 1'b0, 0, 0);
        do_instr(6'h2B, 1'b0, 0, 5);
        do_instr(6'h2B, 1'b0, 0, 4);
        do_instr(6'h00, 1'b0, 5, 0);
        while (m_cnt != (1 << CW) - 1) do_instr(6'h08, 1'b0, 0, 0);
        do_instr(6'h02, 1'b0, 0, 0);

        opcode = 6'h2B;
        cyc(1'b1, 0, 1'b0, 1'b0);
        cyc(1'b1, 1, 1'b0, 1'b0);
        cyc(1'b1, 2, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #1;
        check("mw_pre_rst", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        chk_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int n = 0; n < 300; n++) begin
            int k = int'($urandom_range(0, 7));
            op = (k < 6) ? ops[k] : 6'($urandom_range(0, 63));
            do_instr(op, rnd(), rwait(), rwait());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
